// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiplier FSM
// encoding and bit positions inside the MEM control bundle.
package ex_pkg;

  localparam int SIG_W = 7;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_MUL  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  localparam int SIG_DATAINSRC = 6;
  localparam int SIG_MEMRD     = 5;
  localparam int SIG_MEMWR     = 4;
  localparam int SIG_NBYTE_HI  = 3;
  localparam int SIG_NBYTE_LO  = 2;
  localparam int SIG_WB_HI     = 1;
  localparam int SIG_WB_LO     = 0;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == ALU_MUL);
  endfunction

endpackage

// File: rtl/seq_mult16.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, fixed
// WIDTH-cycle latency, low WIDTH bits of the product.
module seq_mult16
  import ex_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  mul_state_e       state_r;
  mul_state_e       state_s;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] count_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MUL_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = MUL_IDLE;
    end else begin
      case (state_r)
        MUL_IDLE: begin
          if (start) state_s = MUL_BUSY;
          else       state_s = MUL_IDLE;
        end
        MUL_BUSY: begin
          if (count_r == '0) state_s = MUL_DONE;
          else               state_s = MUL_BUSY;
        end
        MUL_DONE: state_s = MUL_IDLE;
        default:  state_s = MUL_IDLE;
      endcase
    end
  end

  // Operand, accumulator and iteration counter datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      count_r  <= '0;
    end else if (flush) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      count_r  <= '0;
    end else begin
      case (state_r)
        MUL_IDLE: begin
          if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= '0;
            count_r  <= CNT_W'(WIDTH - 1);
          end
        end
        MUL_BUSY: begin
          if (mplier_r[0]) acc_r <= acc_r + mcand_r;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          if (count_r != '0) count_r <= count_r - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (state_r == MUL_BUSY);
  assign done    = (state_r == MUL_DONE);
  assign product = acc_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU with iterative multiply, upstream stall handshake and
// the EX/MEM pipeline register feeding the memory stage.
module ex_stage #(
  parameter int WIDTH = 16,
  parameter int SIG_W = ex_pkg::SIG_W,
  parameter int RD_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_EX,
  input  logic             flush,
  input  logic [WIDTH-1:0] valueA_EX,
  input  logic [WIDTH-1:0] valueB_EX,
  input  logic [WIDTH-1:0] immediate_EX,
  input  logic [WIDTH-1:0] PC_EX,
  input  logic             ALUSrc_EX,
  input  logic [2:0]       ALUOp_EX,
  input  logic [SIG_W-1:0] signals_EX,
  input  logic             RegWr_EX,
  input  logic [RD_W-1:0]  rd_EX,
  output logic             stall_EX,
  output logic [WIDTH-1:0] AluResult_MEM,
  output logic [WIDTH-1:0] immediate_MEM,
  output logic [WIDTH-1:0] valueB_MEM,
  output logic [WIDTH-1:0] PC_MEM,
  output logic [SIG_W-1:0] signals_MEM,
  output logic             RegWr_MEM,
  output logic [RD_W-1:0]  rd_MEM,
  output logic             valid_MEM
);

  import ex_pkg::*;

  logic [WIDTH-1:0] op2_s;
  logic [WIDTH-1:0] alu_s;
  logic [WIDTH-1:0] mul_product_s;
  logic             mul_req_s;
  logic             mul_start_s;
  logic             mul_busy_s;
  logic             mul_done_s;
  logic             stall_s;
  logic             load_s;

  logic [WIDTH-1:0] alu_r;
  logic [WIDTH-1:0] imm_r;
  logic [WIDTH-1:0] valb_r;
  logic [WIDTH-1:0] pc_r;
  logic [SIG_W-1:0] sig_r;
  logic             regwr_r;
  logic [RD_W-1:0]  rd_r;
  logic             valid_r;

  assign op2_s     = ALUSrc_EX ? immediate_EX : valueB_EX;
  assign mul_req_s = valid_EX & is_mul(ALUOp_EX);

  // A MUL stalls from first presentation until the DONE cycle, where it is captured
  assign mul_start_s = mul_req_s & ~flush & ~mul_busy_s & ~mul_done_s;
  assign stall_s     = rst_n & ~flush & (mul_busy_s | (mul_req_s & ~mul_done_s));
  assign load_s      = valid_EX & ~flush & ~stall_s;
  assign stall_EX    = stall_s;

  seq_mult16 #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start_s),
    .flush  (flush),
    .a      (valueA_EX),
    .b      (op2_s),
    .busy   (mul_busy_s),
    .done   (mul_done_s),
    .product(mul_product_s)
  );

  // ALU result mux
  always_comb begin
    alu_s = '0;
    case (ALUOp_EX)
      ALU_AND:  alu_s = valueA_EX & op2_s;
      ALU_OR:   alu_s = valueA_EX | op2_s;
      ALU_ADD:  alu_s = valueA_EX + op2_s;
      ALU_SUB:  alu_s = valueA_EX - op2_s;
      ALU_SLL:  alu_s = valueA_EX << op2_s[3:0];
      ALU_SRL:  alu_s = valueA_EX >> op2_s[3:0];
      ALU_MUL:  alu_s = mul_product_s;
      ALU_PASS: alu_s = op2_s;
      default:  alu_s = '0;
    endcase
  end

  // EX/MEM register: capture a real instruction or load a zeroed bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_r   <= '0;
      imm_r   <= '0;
      valb_r  <= '0;
      pc_r    <= '0;
      sig_r   <= '0;
      regwr_r <= 1'b0;
      rd_r    <= '0;
      valid_r <= 1'b0;
    end else if (load_s) begin
      alu_r   <= alu_s;
      imm_r   <= immediate_EX;
      valb_r  <= valueB_EX;
      pc_r    <= PC_EX;
      sig_r   <= signals_EX;
      regwr_r <= RegWr_EX;
      rd_r    <= rd_EX;
      valid_r <= 1'b1;
    end else begin
      alu_r   <= '0;
      imm_r   <= '0;
      valb_r  <= '0;
      pc_r    <= '0;
      sig_r   <= '0;
      regwr_r <= 1'b0;
      rd_r    <= '0;
      valid_r <= 1'b0;
    end
  end

  assign AluResult_MEM = alu_r;
  assign immediate_MEM = imm_r;
  assign valueB_MEM    = valb_r;
  assign PC_MEM        = pc_r;
  assign signals_MEM   = sig_r;
  assign RegWr_MEM     = regwr_r;
  assign rd_MEM        = rd_r;
  assign valid_MEM     = valid_r;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, multi-cycle MUL with
// stall counting, flush, asynchronous reset mid-multiply.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_EX;
  logic        flush;
  logic [15:0] valueA_EX;
  logic [15:0] valueB_EX;
  logic [15:0] immediate_EX;
  logic [15:0] PC_EX;
  logic        ALUSrc_EX;
  logic [2:0]  ALUOp_EX;
  logic [6:0]  signals_EX;
  logic        RegWr_EX;
  logic [2:0]  rd_EX;
  logic        stall_EX;
  logic [15:0] AluResult_MEM;
  logic [15:0] immediate_MEM;
  logic [15:0] valueB_MEM;
  logic [15:0] PC_MEM;
  logic [6:0]  signals_MEM;
  logic        RegWr_MEM;
  logic [2:0]  rd_MEM;
  logic        valid_MEM;

  int n_cmp;
  int n_err;

  ex_stage #(.WIDTH(16), .SIG_W(7), .RD_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_EX     (valid_EX),
    .flush        (flush),
    .valueA_EX    (valueA_EX),
    .valueB_EX    (valueB_EX),
    .immediate_EX (immediate_EX),
    .PC_EX        (PC_EX),
    .ALUSrc_EX    (ALUSrc_EX),
    .ALUOp_EX     (ALUOp_EX),
    .signals_EX   (signals_EX),
    .RegWr_EX     (RegWr_EX),
    .rd_EX        (rd_EX),
    .stall_EX     (stall_EX),
    .AluResult_MEM(AluResult_MEM),
    .immediate_MEM(immediate_MEM),
    .valueB_MEM   (valueB_MEM),
    .PC_MEM       (PC_MEM),
    .signals_MEM  (signals_MEM),
    .RegWr_MEM    (RegWr_MEM),
    .rd_MEM       (rd_MEM),
    .valid_MEM    (valid_MEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    valid_EX     = 1'b0;
    flush        = 1'b0;
    valueA_EX    = 16'h0000;
    valueB_EX    = 16'h0000;
    immediate_EX = 16'h0000;
    PC_EX        = 16'h0000;
    ALUSrc_EX    = 1'b0;
    ALUOp_EX     = 3'b000;
    signals_EX   = 7'b0000000;
    RegWr_EX     = 1'b0;
    rd_EX        = 3'd0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] imm, input logic [15:0] pc, input logic src,
                       input logic [6:0] sig, input logic [2:0] rd, input logic regwr);
    valid_EX     = 1'b1;
    ALUOp_EX     = op;
    valueA_EX    = a;
    valueB_EX    = b;
    immediate_EX = imm;
    PC_EX        = pc;
    ALUSrc_EX    = src;
    signals_EX   = sig;
    rd_EX        = rd;
    RegWr_EX     = regwr;
  endtask

  // Presents a MUL, holds it while stalled, counts stall cycles and bubbles.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        output int stalls, output int bubbles,
                        output logic [15:0] result, output logic [6:0] sig,
                        output logic res_valid, output logic timed_out);
    stalls    = 0;
    bubbles   = 0;
    timed_out = 1'b1;
    issue(3'b110, a, b, 16'h0000, 16'h0200, 1'b0, 7'b1000011, 3'd5, 1'b1);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall_EX !== 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      stalls++;
      @(posedge clk); #1;
      if (valid_MEM === 1'b0 && signals_MEM === 7'b0000000) bubbles++;
    end
    @(posedge clk); #1;
    result    = AluResult_MEM;
    sig       = signals_MEM;
    res_valid = valid_MEM;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({AluResult_MEM, immediate_MEM, valueB_MEM, PC_MEM, signals_MEM, RegWr_MEM, rd_MEM, valid_MEM} !== 76'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got alu=%h sig=%b valid=%b, expected all zero", AluResult_MEM, signals_MEM, valid_MEM);
    end
    n_cmp++;
    if (stall_EX !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall: got %b expected 0", stall_EX);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    issue(3'b010, 16'h0005, 16'h0003, 16'h00AA, 16'h0100, 1'b0, 7'b0100010, 3'd3, 1'b1);
    #1;
    n_cmp++;
    if (stall_EX !== 1'b0) begin
      n_err++;
      $display("FAIL add_stall: got %b expected 0", stall_EX);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (AluResult_MEM !== 16'h0008) begin
      n_err++;
      $display("FAIL add_result: got %h expected 0008", AluResult_MEM);
    end
    n_cmp++;
    if ({signals_MEM, valid_MEM, RegWr_MEM, rd_MEM} !== {7'b0100010, 1'b1, 1'b1, 3'd3}) begin
      n_err++;
      $display("FAIL add_ctrl: got sig=%b valid=%b regwr=%b rd=%0d expected 0100010/1/1/3",
               signals_MEM, valid_MEM, RegWr_MEM, rd_MEM);
    end
    n_cmp++;
    if ({immediate_MEM, valueB_MEM, PC_MEM} !== {16'h00AA, 16'h0003, 16'h0100}) begin
      n_err++;
      $display("FAIL add_fields: got imm=%h valB=%h pc=%h expected 00aa/0003/0100",
               immediate_MEM, valueB_MEM, PC_MEM);
    end
    idle_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if ({valid_MEM, signals_MEM, RegWr_MEM} !== 9'd0) begin
      n_err++;
      $display("FAIL idle_bubble: got valid=%b sig=%b regwr=%b expected zeros", valid_MEM, signals_MEM, RegWr_MEM);
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  ops [7];
    logic [15:0] as  [7];
    logic [15:0] bs  [7];
    logic [15:0] ims [7];
    logic        srcs[7];
    logic [15:0] exps[7];
    // SUB wrap, SLL by imm[3:0], AND, OR, SRL, PASS imm, ADD wrap
    ops = '{3'b011, 3'b100, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010};
    as  = '{16'h0000, 16'h0001, 16'h00F0, 16'h00F0, 16'h8000, 16'h1111, 16'hFFFF};
    bs  = '{16'h7777, 16'h7777, 16'h0FF0, 16'h0F0F, 16'h0000, 16'h2222, 16'h0002};
    ims = '{16'h0001, 16'h0014, 16'h0000, 16'h0000, 16'h0003, 16'hBEEF, 16'h0000};
    srcs= '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exps= '{16'hFFFF, 16'h0010, 16'h00F0, 16'h0FFF, 16'h1000, 16'hBEEF, 16'h0001};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], as[i], bs[i], ims[i], 16'h0040, srcs[i], 7'b0001100, 3'd1, 1'b1);
      @(posedge clk); #1;
      n_cmp++;
      if (AluResult_MEM !== exps[i] || valid_MEM !== 1'b1) begin
        n_err++;
        $display("FAIL alu_op%0d: got %h valid=%b expected %h valid=1", i, AluResult_MEM, valid_MEM, exps[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if (immediate_MEM !== 16'h0001) begin
          n_err++;
          $display("FAIL sub_imm_field: got %h expected 0001", immediate_MEM);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_mul();
    int st, bb;
    logic [15:0] res;
    logic [6:0]  sig;
    logic v, to;
    do_mul(16'h0012, 16'h0034, st, bb, res, sig, v, to);
    n_cmp++;
    if (to !== 1'b0 || st != 17) begin
      n_err++;
      $display("FAIL mul_stall_len: got %0d cycles timeout=%b expected 17", st, to);
    end
    n_cmp++;
    if (bb != 17) begin
      n_err++;
      $display("FAIL mul_bubbles: got %0d expected 17", bb);
    end
    n_cmp++;
    if (res !== 16'h03A8 || v !== 1'b1 || sig !== 7'b1000011) begin
      n_err++;
      $display("FAIL mul_result: got %h valid=%b sig=%b expected 03a8 valid=1 sig=1000011", res, v, sig);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] as  [3];
    logic [15:0] bs  [3];
    logic [15:0] exps[3];
    int st, bb;
    logic [15:0] res;
    logic [6:0]  sig;
    logic v, to;
    as   = '{16'h0100, 16'hFFFF, 16'h1234};
    bs   = '{16'h0100, 16'h0002, 16'h0000};
    exps = '{16'h0000, 16'hFFFE, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      do_mul(as[i], bs[i], st, bb, res, sig, v, to);
      n_cmp++;
      if (to !== 1'b0 || st != 17 || bb != 17) begin
        n_err++;
        $display("FAIL b2b_stall%0d: got stalls=%0d bubbles=%0d timeout=%b expected 17/17/0", i, st, bb, to);
      end
      n_cmp++;
      if (res !== exps[i] || v !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_result%0d: got %h valid=%b expected %h valid=1", i, res, v, exps[i]);
      end
    end
  endtask

  task automatic test_flush();
    issue(3'b110, 16'h0007, 16'h0009, 16'h0000, 16'h0300, 1'b0, 7'b1000011, 3'd2, 1'b1);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (stall_EX !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre_stall: got %b expected 1", stall_EX);
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (stall_EX !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall: got %b expected 0", stall_EX);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (valid_MEM !== 1'b0 || signals_MEM !== 7'b0000000) begin
      n_err++;
      $display("FAIL flush_bubble: got valid=%b sig=%b expected 0/0000000", valid_MEM, signals_MEM);
    end
    flush = 1'b0;
    issue(3'b010, 16'h0002, 16'h0002, 16'h0000, 16'h0302, 1'b0, 7'b0000001, 3'd4, 1'b1);
    #1;
    n_cmp++;
    if (stall_EX !== 1'b0) begin
      n_err++;
      $display("FAIL post_flush_stall: got %b expected 0", stall_EX);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (AluResult_MEM !== 16'h0004 || valid_MEM !== 1'b1) begin
      n_err++;
      $display("FAIL post_flush_add: got %h valid=%b expected 0004 valid=1", AluResult_MEM, valid_MEM);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    int st, bb;
    logic [15:0] res;
    logic [6:0]  sig;
    logic v, to;
    // Reset right after a capture must clear a non-zero EX/MEM register
    issue(3'b111, 16'h0000, 16'h0000, 16'h5A5A, 16'h0404, 1'b1, 7'b1111111, 3'd7, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({AluResult_MEM, immediate_MEM, valueB_MEM, PC_MEM, signals_MEM, RegWr_MEM, rd_MEM, valid_MEM} !== 76'd0) begin
      n_err++;
      $display("FAIL async_clear: got alu=%h imm=%h pc=%h sig=%b valid=%b expected zeros",
               AluResult_MEM, immediate_MEM, PC_MEM, signals_MEM, valid_MEM);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'b110, 16'h0055, 16'h0003, 16'h0000, 16'h0500, 1'b0, 7'b1000011, 3'd6, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (stall_EX !== 1'b0 || valid_MEM !== 1'b0 || AluResult_MEM !== 16'h0000) begin
      n_err++;
      $display("FAIL async_mid_busy: got stall=%b valid=%b alu=%h expected 0/0/0000", stall_EX, valid_MEM, AluResult_MEM);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_mul(16'h0003, 16'h0004, st, bb, res, sig, v, to);
    n_cmp++;
    if (to !== 1'b0 || st != 17) begin
      n_err++;
      $display("FAIL reissue_stall: got %0d cycles timeout=%b expected 17", st, to);
    end
    n_cmp++;
    if (res !== 16'h000C || v !== 1'b1) begin
      n_err++;
      $display("FAIL reissue_result: got %h valid=%b expected 000c valid=1", res, v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
